mpu6050_ctrl: RTL and testbench
===============================

Name: mpu6050_ctrl

Overview:
Sequencer that drives the I2C byte-level master to bring the MPU6050 out of sleep and then periodically burst-read its sensor registers. It issues byte commands to the master, collects the returned bytes and assembles them into signed 16-bit samples. It sits between the i2c_master instance and the game/sensor logic, and it is the only client of the master.

Parameters:
STARTUP_CYCLES, 5000000, clk cycles to wait after reset before the first transaction (100 ms at 50 MHz)
SAMPLE_DIV, 50000, clk cycles between the starts of consecutive read bursts (1 kHz at 50 MHz)
RETRY_MAX, 3, consecutive NACK-aborted transactions tolerated before entering ERROR
CMD_TIMEOUT, 65535, max clk cycles to wait for i2c_done per command

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
i2c_cmd  out  3  1=START_W, 2=START_R, 3=WRITE, 4=READ_ACK, 5=READ_NACK, 6=STOP; the master sends the slave address on START_*
i2c_cmd_valid  out  1  one-cycle command strobe
i2c_wdata  out  8  byte for WRITE
i2c_busy  in  1  master executing a command
i2c_done  in  1  one-cycle pulse when the command completes
i2c_ack_err  in  1  qualifies i2c_done; slave NACKed the address or write byte
i2c_rdata  in  8  byte valid with i2c_done after READ_*
accel_x, accel_y, accel_z  out  16 each  latest signed samples
gyro_x, gyro_y, gyro_z  out  16 each  gyro samples; present only with the feature enabled
sample_valid  out  1  one-cycle pulse when a new sample set is published
init_done  out  1  high once the wake write has succeeded
error  out  1  sticky, set after RETRY_MAX failures

Behaviour:
- Reset (synchronous, active-high) puts the block in STARTUP.
  - All sample outputs = 0; sample_valid, init_done, error, i2c_cmd_valid = 0; i2c_cmd = 0; i2c_wdata = 0.
  - Retry counter = 0; all timers cleared.
  - Reset mid-transaction abandons the transaction; no STOP is issued.
- Command issue: i2c_cmd_valid is asserted for exactly one cycle, only when i2c_busy = 0. The FSM then waits for i2c_done.
  - At most one command is outstanding.
  - i2c_done with i2c_ack_err = 1 on START_W, START_R or WRITE -> issue STOP, increment the retry counter, go to HOLDOFF.
  - No i2c_done within CMD_TIMEOUT cycles is handled the same way as a NACK.
- States:
  - STARTUP: count STARTUP_CYCLES, then go to WAKE.
  - WAKE: START_W, WRITE 0x6B, WRITE 0x00, STOP.
    - On success: init_done = 1, retry counter = 0, go to WAIT.
    - On failure: go to HOLDOFF, which returns to WAKE.
  - WAIT: sample timer counts SAMPLE_DIV cycles; the timer is free-running from init_done so the burst period is exact. At terminal count go to RD_PTR.
  - RD_PTR: START_W, WRITE 0x3B. Repeated start with no STOP, then go to RD_DATA.
  - RD_DATA: START_R, then N reads.
    - The first N-1 reads are READ_ACK; the last is READ_NACK; then STOP.
    - N = 6 by default.
    - Bytes are stored big-endian: byte 2k is the high byte, byte 2k+1 the low byte.
  - PUBLISH: copy the shadow buffer to the outputs in a single cycle and pulse sample_valid on that same cycle; retry counter = 0; return to WAIT.
  - HOLDOFF: wait 1000 cycles after the STOP completes, then retry the aborted transaction.
    - If the retry counter equals RETRY_MAX, go to ERROR instead.
  - ERROR: set error; issue no further commands until reset.
- Outputs are never partially updated. A failed burst leaves the previous sample on the outputs.
- If the sample timer expires while a burst is still running, that tick is dropped; no queueing.

Optional Feature:
MPU6050_GYRO_EN
- Defined:
  - N = 14 (registers 0x3B..0x48).
  - Bytes 6-7 hold temperature and are discarded.
  - Bytes 8-13 go to gyro_x, gyro_y, gyro_z.
  - The gyro ports exist.
- Undefined:
  - N = 6.
  - The gyro ports and the gyro shadow registers are omitted.

Test Plan:
- Assert reset, with STARTUP_CYCLES=20 -> no i2c_cmd_valid for 20 cycles after reset deasserts; then the sequence START_W, WRITE 0x6B, WRITE 0x00, STOP; init_done rises one cycle after the STOP's i2c_done.
- Master model returns bytes 0x12,0x34,0xFF,0xFE,0x80,0x00 -> accel_x=0x1234, accel_y=0xFFFE, accel_z=0x8000; exactly one sample_valid pulse; the last read uses READ_NACK.
- SAMPLE_DIV=200 -> START_W of consecutive bursts spaced exactly 200 cycles apart.
- ack_err on the address of the first 3 WAKE attempts, with RETRY_MAX=3 -> 3 STOPs; error=1; no commands afterwards; init_done stays 0.
- NACK on WRITE 0x3B during a read, after a good sample -> outputs keep the old values; no sample_valid; the retry succeeds and publishes.
- Reset asserted during RD_DATA -> all outputs 0 the next cycle; the sequence restarts at STARTUP. With MPU6050_GYRO_EN defined, 14 reads are issued and gyro_x equals bytes 8-9.

Source files
------------

// File: rtl/mpu6050_ctrl_if.sv
// Byte-command bus between mpu6050_ctrl (master side) and the I2C byte-level
// master engine (slave side).
interface mpu6050_ctrl_if;
  logic [2:0] i2c_cmd;
  logic       i2c_cmd_valid;
  logic [7:0] i2c_wdata;
  logic       i2c_busy;
  logic       i2c_done;
  logic       i2c_ack_err;
  logic [7:0] i2c_rdata;

  modport master (
    output i2c_cmd, i2c_cmd_valid, i2c_wdata,
    input  i2c_busy, i2c_done, i2c_ack_err, i2c_rdata
  );

  modport slave (
    input  i2c_cmd, i2c_cmd_valid, i2c_wdata,
    output i2c_busy, i2c_done, i2c_ack_err, i2c_rdata
  );
endinterface

// File: rtl/mpu6050_ctrl.sv
// MPU6050 sequencer: wakes the sensor, then burst-reads 0x3B.. every SAMPLE_DIV
// cycles into signed 16-bit samples. Define MPU6050_GYRO_EN to also read the gyro.
module mpu6050_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 5000000,
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned CMD_TIMEOUT    = 65535,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  mpu6050_ctrl_if.master        bus,
  output logic [15:0]           accel_x,
  output logic [15:0]           accel_y,
  output logic [15:0]           accel_z,
`ifdef MPU6050_GYRO_EN
  output logic [15:0]           gyro_x,
  output logic [15:0]           gyro_y,
  output logic [15:0]           gyro_z,
`endif
  output logic                  sample_valid,
  output logic                  init_done,
  output logic                  error
);

`ifdef MPU6050_GYRO_EN
  localparam int NBYTES = 14;
`else
  localparam int NBYTES = 6;
`endif
  localparam int NWORDS = NBYTES / 2;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [3:0] NB   = 4'(NBYTES);
  localparam logic [7:0] RMAX = 8'(RETRY_MAX);

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_START_W   = 3'd1;
  localparam logic [2:0] CMD_START_R   = 3'd2;
  localparam logic [2:0] CMD_WRITE     = 3'd3;
  localparam logic [2:0] CMD_READ_ACK  = 3'd4;
  localparam logic [2:0] CMD_READ_NACK = 3'd5;
  localparam logic [2:0] CMD_STOP      = 3'd6;

  typedef enum logic [2:0] {
    ST_STARTUP, ST_WAKE, ST_WAIT, ST_RD_PTR,
    ST_RD_DATA, ST_PUBLISH, ST_HOLDOFF, ST_ERROR
  } state_t;

  state_t      state_q, retry_st_q;
  logic [3:0]  step_q;
  logic        pend_q;
  logic [31:0] tmo_q, cnt_q, samp_q;
  logic [7:0]  retry_q;
  logic [2:0]  cmd_q;
  logic [7:0]  wdata_q;
  logic        cmd_valid_q;
  logic        sample_valid_q, init_done_q, error_q;
  logic [15:0] accel_x_q, accel_y_q, accel_z_q;
`ifdef MPU6050_GYRO_EN
  logic [15:0] gyro_x_q, gyro_y_q, gyro_z_q;
`endif
  logic [7:0]  shadow_q [NBYTES];

  logic [2:0]    cmd_d;
  logic [7:0]    wdata_d;
  logic          last_d, cmd_st_d, ack_chk_d, tmo_hit_d, samp_tc_d, rd_byte_d;
  logic [IW-1:0] widx_d;
  logic [15:0]   word_d [NWORDS];

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      assign word_d[gi] = {shadow_q[2*gi], shadow_q[2*gi+1]};
    end
  endgenerate

  // Command issued in the current (state, step); last_d marks the final command of a transaction.
  always_comb begin
    cmd_d    = CMD_NONE;
    wdata_d  = 8'h00;
    last_d   = 1'b0;
    cmd_st_d = 1'b0;
    case (state_q)
      ST_WAKE: begin
        cmd_st_d = 1'b1;
        case (step_q)
          4'd0: cmd_d = CMD_START_W;
          4'd1: begin cmd_d = CMD_WRITE; wdata_d = 8'h6B; end
          4'd2: begin cmd_d = CMD_WRITE; wdata_d = 8'h00; end
          default: begin cmd_d = CMD_STOP; last_d = 1'b1; end
        endcase
      end
      ST_RD_PTR: begin
        cmd_st_d = 1'b1;
        if (step_q == 4'd0) begin
          cmd_d = CMD_START_W;
        end else begin
          cmd_d   = CMD_WRITE;
          wdata_d = 8'h3B;
          last_d  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        cmd_st_d = 1'b1;
        if (step_q == 4'd0)     cmd_d = CMD_START_R;
        else if (step_q < NB)   cmd_d = CMD_READ_ACK;
        else if (step_q == NB)  cmd_d = CMD_READ_NACK;
        else begin
          cmd_d  = CMD_STOP;
          last_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        cmd_st_d = (step_q == 4'd0);
        cmd_d    = CMD_STOP;
      end
      default: ;
    endcase
  end

  assign ack_chk_d = (cmd_d == CMD_START_W) || (cmd_d == CMD_START_R) || (cmd_d == CMD_WRITE);
  assign tmo_hit_d = pend_q && !bus.i2c_done && (tmo_q >= CMD_TIMEOUT);
  assign samp_tc_d = init_done_q && (samp_q == SAMPLE_DIV - 1);
  assign rd_byte_d = (state_q == ST_RD_DATA) && (step_q != 4'd0) && (step_q <= NB);
  assign widx_d    = IW'(step_q - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_STARTUP;
      retry_st_q     <= ST_WAKE;
      step_q         <= 4'd0;
      pend_q         <= 1'b0;
      tmo_q          <= '0;
      cnt_q          <= '0;
      samp_q         <= '0;
      retry_q        <= '0;
      cmd_q          <= CMD_NONE;
      wdata_q        <= 8'h00;
      cmd_valid_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      error_q        <= 1'b0;
      accel_x_q      <= '0;
      accel_y_q      <= '0;
      accel_z_q      <= '0;
`ifdef MPU6050_GYRO_EN
      gyro_x_q       <= '0;
      gyro_y_q       <= '0;
      gyro_z_q       <= '0;
`endif
      for (int i = 0; i < NBYTES; i++) shadow_q[i] <= 8'h00;
    end else begin
      cmd_valid_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      // Burst period is measured from init_done, independent of burst length.
      if (init_done_q) samp_q <= samp_tc_d ? '0 : samp_q + 32'd1;

      case (state_q)
        ST_STARTUP: begin
          if (cnt_q == STARTUP_CYCLES - 1) begin
            cnt_q   <= '0;
            step_q  <= 4'd0;
            state_q <= ST_WAKE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_WAIT: begin
          if (samp_tc_d) begin
            step_q  <= 4'd0;
            state_q <= ST_RD_PTR;
          end
        end
        ST_PUBLISH: begin
          accel_x_q      <= word_d[0];
          accel_y_q      <= word_d[1];
          accel_z_q      <= word_d[2];
`ifdef MPU6050_GYRO_EN
          gyro_x_q       <= word_d[4];
          gyro_y_q       <= word_d[5];
          gyro_z_q       <= word_d[6];
`endif
          sample_valid_q <= 1'b1;
          retry_q        <= '0;
          state_q        <= ST_WAIT;
        end
        ST_HOLDOFF: begin
          if (step_q != 4'd0) begin
            if (cnt_q == HOLDOFF_CYCLES - 1) begin
              if (retry_q == RMAX) begin
                error_q <= 1'b1;
                state_q <= ST_ERROR;
              end else begin
                step_q  <= 4'd0;
                state_q <= retry_st_q;
              end
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
        ST_ERROR: error_q <= 1'b1;
        default: ;
      endcase

      if (cmd_st_d) begin
        if (!pend_q) begin
          if (!bus.i2c_busy) begin
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            cmd_valid_q <= 1'b1;
            pend_q      <= 1'b1;
            tmo_q       <= '0;
          end
        end else if (bus.i2c_done || tmo_hit_d) begin
          pend_q <= 1'b0;
          if (state_q == ST_HOLDOFF) begin
            // Abort STOP finished (or gave up): start the holdoff wait.
            step_q <= 4'd1;
            cnt_q  <= '0;
          end else if (tmo_hit_d || (bus.i2c_ack_err && ack_chk_d)) begin
            retry_q    <= retry_q + 8'd1;
            retry_st_q <= (state_q == ST_WAKE) ? ST_WAKE : ST_RD_PTR;
            step_q     <= 4'd0;
            cnt_q      <= '0;
            state_q    <= ST_HOLDOFF;
          end else begin
            if (rd_byte_d) shadow_q[widx_d] <= bus.i2c_rdata;
            if (!last_d) begin
              step_q <= step_q + 4'd1;
            end else if (state_q == ST_WAKE) begin
              init_done_q <= 1'b1;
              retry_q     <= '0;
              state_q     <= ST_WAIT;
            end else if (state_q == ST_RD_PTR) begin
              step_q  <= 4'd0;
              state_q <= ST_RD_DATA;
            end else begin
              state_q <= ST_PUBLISH;
            end
          end
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end
    end
  end

  assign bus.i2c_cmd       = cmd_q;
  assign bus.i2c_cmd_valid = cmd_valid_q;
  assign bus.i2c_wdata     = wdata_q;
  assign accel_x           = accel_x_q;
  assign accel_y           = accel_y_q;
  assign accel_z           = accel_z_q;
`ifdef MPU6050_GYRO_EN
  assign gyro_x            = gyro_x_q;
  assign gyro_y            = gyro_y_q;
  assign gyro_z            = gyro_z_q;
`endif
  assign sample_valid      = sample_valid_q;
  assign init_done         = init_done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_mpu6050_ctrl.sv
// Directed bench for mpu6050_ctrl with a behavioural I2C byte-master model.
`timescale 1ns/1ps
module tb_mpu6050_ctrl;
`ifdef MPU6050_GYRO_EN
  localparam int NB = 14;
`else
  localparam int NB = 6;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mpu6050_ctrl_if bus();
  logic [15:0] accel_x, accel_y, accel_z;
`ifdef MPU6050_GYRO_EN
  logic [15:0] gyro_x, gyro_y, gyro_z;
`endif
  logic sample_valid, init_done, error;

  mpu6050_ctrl #(
    .STARTUP_CYCLES(20), .SAMPLE_DIV(200), .RETRY_MAX(3), .CMD_TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
`ifdef MPU6050_GYRO_EN
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
`endif
    .sample_valid(sample_valid), .init_done(init_done), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // master model state and transaction log
  int         m_cnt = 0;
  logic [2:0] m_cmd;
  logic       m_err;
  logic [7:0] m_rd;
  int         rd_idx = 0;
  logic [7:0] tbl [14];
  int         nack_addr = 0;
  int         nack_3b = 0;
  bit         nack_hit = 0;
  int         nack_idx = 0;
  bit         sr_seen = 0;
  int         viol = 0;
  int         cyc = 0;
  int         stop_done_cyc = -1;
  int         init_rise_cyc = -1;
  bit         init_seen = 0;
  int         sv_cnt = 0;
  int         sw_cyc [$];
  logic [2:0] lg_cmd [$];
  logic [7:0] lg_wd [$];
  int         wake_base = 0;

  initial begin
    bus.i2c_busy = 1'b0; bus.i2c_done = 1'b0; bus.i2c_ack_err = 1'b0; bus.i2c_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.i2c_done = 1'b0;
      bus.i2c_ack_err = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.i2c_done = 1'b1; bus.i2c_busy = 1'b0;
          bus.i2c_ack_err = m_err; bus.i2c_rdata = m_rd;
          if (m_cmd == 3'd6) stop_done_cyc = cyc;
        end
      end
      if (bus.i2c_cmd_valid) begin
        if (bus.i2c_busy) viol++;
        m_cmd = bus.i2c_cmd; m_err = 1'b0; m_rd = 8'h00;
        lg_cmd.push_back(bus.i2c_cmd);
        lg_wd.push_back(bus.i2c_wdata);
        if (bus.i2c_cmd == 3'd1) begin
          sw_cyc.push_back(cyc);
          if (nack_addr > 0) begin m_err = 1'b1; nack_addr--; end
        end
        if (bus.i2c_cmd == 3'd2) begin rd_idx = 0; sr_seen = 1; end
        if (bus.i2c_cmd == 3'd3 && bus.i2c_wdata == 8'h3B && nack_3b > 0) begin
          m_err = 1'b1; nack_3b--; nack_hit = 1; nack_idx = lg_cmd.size() - 1;
        end
        if (bus.i2c_cmd == 3'd4 || bus.i2c_cmd == 3'd5) begin
          m_rd = tbl[rd_idx % 14]; rd_idx++;
        end
        bus.i2c_busy = 1'b1;
        m_cnt = 3;
      end
      if (sample_valid) sv_cnt++;
      if (init_done && !init_seen) begin init_seen = 1; init_rise_cyc = cyc; end
    end
  end

  task automatic test_reset();
    int nv;
    nv = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (bus.i2c_cmd_valid !== 1'b0 || bus.i2c_cmd !== 3'd0 || bus.i2c_wdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_bus: valid=%b cmd=%0d wdata=%h, required 0/0/00", bus.i2c_cmd_valid, bus.i2c_cmd, bus.i2c_wdata); end
    n_cmp++; if ({accel_x, accel_y, accel_z} !== 48'h0 || {sample_valid, init_done, error} !== 3'b000) begin
      n_bad++; $display("FAIL reset_out: accel=%h %h %h sv/id/err=%b%b%b, required all 0", accel_x, accel_y, accel_z, sample_valid, init_done, error); end
    wake_base = lg_cmd.size();
    init_seen = 0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (bus.i2c_cmd_valid) nv++;
    end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL startup_quiet: %0d strobes in first 20 cycles, required 0", nv); end
    @(posedge clk); #2;
    n_cmp++; if (bus.i2c_cmd_valid !== 1'b1 || bus.i2c_cmd !== 3'd1) begin
      n_bad++; $display("FAIL first_cmd: valid=%b cmd=%0d at cycle 21, required 1/START_W", bus.i2c_cmd_valid, bus.i2c_cmd); end
  endtask

  task automatic test_wake();
    int t;
    t = 0;
    while (!init_done && t < 300) begin @(posedge clk); #2; t++; end
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL wake_wait: init_done=%b after 300 cycles, required 1", init_done); end
    n_cmp++; if (lg_cmd.size() < wake_base + 4) begin
      n_bad++; $display("FAIL wake_len: %0d commands, required 4", lg_cmd.size() - wake_base);
    end else begin
      n_cmp++; if (lg_cmd[wake_base] !== 3'd1 || lg_cmd[wake_base+1] !== 3'd3 || lg_wd[wake_base+1] !== 8'h6B ||
                   lg_cmd[wake_base+2] !== 3'd3 || lg_wd[wake_base+2] !== 8'h00 || lg_cmd[wake_base+3] !== 3'd6) begin
        n_bad++; $display("FAIL wake_seq: got %0d,%0d/%h,%0d/%h,%0d required 1,3/6b,3/00,6", lg_cmd[wake_base],
          lg_cmd[wake_base+1], lg_wd[wake_base+1], lg_cmd[wake_base+2], lg_wd[wake_base+2], lg_cmd[wake_base+3]); end
    end
    n_cmp++; if (init_rise_cyc !== stop_done_cyc + 1) begin
      n_bad++; $display("FAIL init_timing: init_done rose at %0d, required %0d", init_rise_cyc, stop_done_cyc + 1); end
    n_cmp++; if (error !== 1'b0 || sv_cnt !== 0) begin n_bad++; $display("FAIL wake_side: error=%b sv=%0d, required 0/0", error, sv_cnt); end
  endtask

  task automatic test_read_burst();
    int base, sv0, t;
    logic [2:0] e;
    base = lg_cmd.size(); sv0 = sv_cnt; t = 0;
    while (sv_cnt == sv0 && t < 1000) begin @(posedge clk); #2; t++; end
    n_cmp++; if (sv_cnt == sv0) begin n_bad++; $display("FAIL burst_wait: no sample_valid in 1000 cycles"); end
    n_cmp++; if (accel_x !== 16'h1234 || accel_y !== 16'hFFFE || accel_z !== 16'h8000) begin
      n_bad++; $display("FAIL accel_val: %h %h %h, required 1234 fffe 8000", accel_x, accel_y, accel_z); end
`ifdef MPU6050_GYRO_EN
    n_cmp++; if (gyro_x !== 16'h0A0B || gyro_y !== 16'hC0DE || gyro_z !== 16'h7FFF) begin
      n_bad++; $display("FAIL gyro_val: %h %h %h, required 0a0b c0de 7fff", gyro_x, gyro_y, gyro_z); end
`endif
    n_cmp++; if (lg_cmd.size() < base + NB + 4) begin
      n_bad++; $display("FAIL burst_len: %0d commands, required %0d", lg_cmd.size() - base, NB + 4);
    end else begin
      for (int i = 0; i < NB + 4; i++) begin
        if (i == 0) e = 3'd1; else if (i == 1) e = 3'd3; else if (i == 2) e = 3'd2;
        else if (i < NB + 2) e = 3'd4; else if (i == NB + 2) e = 3'd5; else e = 3'd6;
        n_cmp++; if (lg_cmd[base+i] !== e) begin n_bad++; $display("FAIL burst_cmd[%0d]: got %0d, required %0d", i, lg_cmd[base+i], e); end
      end
      n_cmp++; if (lg_wd[base+1] !== 8'h3B) begin n_bad++; $display("FAIL burst_ptr: wdata=%h, required 3b", lg_wd[base+1]); end
    end
    repeat (5) @(posedge clk);
    #2;
    n_cmp++; if (sv_cnt !== sv0 + 1 || sample_valid !== 1'b0) begin
      n_bad++; $display("FAIL sv_pulse: %0d pulses, sv=%b, required 1 pulse then 0", sv_cnt - sv0, sample_valid); end
  endtask

  task automatic test_sample_period();
    int n, t;
    n = sw_cyc.size(); t = 0;
    while (sw_cyc.size() < n + 2 && t < 1000) begin @(posedge clk); #2; t++; end
    n_cmp++; if (sw_cyc.size() < n + 2) begin
      n_bad++; $display("FAIL period_wait: %0d bursts seen, required 2", sw_cyc.size() - n);
    end else begin
      n_cmp++; if (sw_cyc[n] - sw_cyc[n-1] !== 200) begin n_bad++; $display("FAIL period_a: %0d cycles, required 200", sw_cyc[n] - sw_cyc[n-1]); end
      n_cmp++; if (sw_cyc[n+1] - sw_cyc[n] !== 200) begin n_bad++; $display("FAIL period_b: %0d cycles, required 200", sw_cyc[n+1] - sw_cyc[n]); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL busy_issue: %0d strobes while busy, required 0", viol); end
  endtask

  task automatic test_nack_read();
    int sv0, t;
    sv0 = sv_cnt; t = 0;
    while (sv_cnt == sv0 && t < 400) begin @(posedge clk); #2; t++; end
    tbl[0] = 8'hAB; tbl[1] = 8'hCD; tbl[2] = 8'h01; tbl[3] = 8'h02; tbl[4] = 8'h03; tbl[5] = 8'h04;
    nack_hit = 0; nack_3b = 1; sv0 = sv_cnt; t = 0;
    while (!nack_hit && t < 400) begin @(posedge clk); #2; t++; end
    n_cmp++; if (!nack_hit) begin n_bad++; $display("FAIL nack_wait: no WRITE 3b in 400 cycles"); end
    repeat (300) @(posedge clk);
    #2;
    n_cmp++; if (lg_cmd.size() <= nack_idx + 1 || lg_cmd[nack_idx+1] !== 3'd6) begin
      n_bad++; $display("FAIL nack_stop: command after NACK not STOP (log size %0d)", lg_cmd.size()); end
    n_cmp++; if (accel_x !== 16'h1234 || accel_y !== 16'hFFFE || accel_z !== 16'h8000 || sv_cnt !== sv0) begin
      n_bad++; $display("FAIL nack_hold: %h %h %h sv+%0d, required 1234 fffe 8000 sv+0", accel_x, accel_y, accel_z, sv_cnt - sv0); end
    t = 0;
    while (sv_cnt == sv0 && t < 2000) begin @(posedge clk); #2; t++; end
    n_cmp++; if (accel_x !== 16'hABCD || accel_y !== 16'h0102 || accel_z !== 16'h0304 || error !== 1'b0) begin
      n_bad++; $display("FAIL retry_pub: %h %h %h err=%b, required abcd 0102 0304 0", accel_x, accel_y, accel_z, error); end
  endtask

  task automatic test_reset_mid_rd();
    int t, base;
    sr_seen = 0; t = 0;
    while (!sr_seen && t < 400) begin @(posedge clk); #2; t++; end
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #2;
    n_cmp++; if ({accel_x, accel_y, accel_z} !== 48'h0 || {sample_valid, init_done, error} !== 3'b000) begin
      n_bad++; $display("FAIL midrd_out: accel=%h %h %h sv/id/err=%b%b%b, required 0", accel_x, accel_y, accel_z, sample_valid, init_done, error); end
`ifdef MPU6050_GYRO_EN
    n_cmp++; if ({gyro_x, gyro_y, gyro_z} !== 48'h0) begin n_bad++; $display("FAIL midrd_gyro: %h %h %h, required 0", gyro_x, gyro_y, gyro_z); end
`endif
    n_cmp++; if (bus.i2c_cmd_valid !== 1'b0 || bus.i2c_cmd !== 3'd0) begin
      n_bad++; $display("FAIL midrd_bus: valid=%b cmd=%0d, required 0/0", bus.i2c_cmd_valid, bus.i2c_cmd); end
    base = lg_cmd.size(); init_seen = 0;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    n_cmp++; if (lg_cmd.size() !== base) begin n_bad++; $display("FAIL midrd_quiet: %0d commands in STARTUP, required 0", lg_cmd.size() - base); end
    t = 0;
    while (!init_done && t < 300) begin @(posedge clk); #2; t++; end
    n_cmp++; if (!init_done || lg_cmd.size() < base + 4 || lg_cmd[base] !== 3'd1 || lg_cmd[base+3] !== 3'd6) begin
      n_bad++; $display("FAIL midrd_restart: init_done=%b first cmd %0d, required 1 and START_W..STOP", init_done,
        (lg_cmd.size() > base) ? lg_cmd[base] : 3'd0); end
  endtask

  task automatic test_retry_error();
    int t, base, nsw, nst, sz, sv0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    nack_addr = 3; base = lg_cmd.size(); init_seen = 0;
    reset = 1'b0;
    t = 0;
    while (!error && t < 6000) begin @(posedge clk); #2; t++; end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_set: error=%b after 6000 cycles, required 1", error); end
    nsw = 0; nst = 0;
    for (int i = base; i < lg_cmd.size(); i++) begin
      if (lg_cmd[i] == 3'd1) nsw++;
      if (lg_cmd[i] == 3'd6) nst++;
    end
    n_cmp++; if (nsw !== 3 || nst !== 3 || lg_cmd.size() - base !== 6) begin
      n_bad++; $display("FAIL err_seq: %0d START_W %0d STOP %0d total, required 3/3/6", nsw, nst, lg_cmd.size() - base); end
    sz = lg_cmd.size(); sv0 = sv_cnt;
    repeat (500) @(posedge clk);
    #2;
    n_cmp++; if (lg_cmd.size() !== sz || sv_cnt !== sv0) begin
      n_bad++; $display("FAIL err_quiet: %0d commands after ERROR, required 0", lg_cmd.size() - sz); end
    n_cmp++; if (init_done !== 1'b0 || error !== 1'b1) begin
      n_bad++; $display("FAIL err_flags: init_done=%b error=%b, required 0/1", init_done, error); end
  endtask

  initial begin
    tbl[0] = 8'h12; tbl[1] = 8'h34; tbl[2] = 8'hFF; tbl[3] = 8'hFE; tbl[4] = 8'h80; tbl[5] = 8'h00;
    tbl[6] = 8'h55; tbl[7] = 8'h66; tbl[8] = 8'h0A; tbl[9] = 8'h0B;
    tbl[10] = 8'hC0; tbl[11] = 8'hDE; tbl[12] = 8'h7F; tbl[13] = 8'hFF;
    test_reset();
    test_wake();
    test_read_burst();
    test_sample_period();
    test_nack_read();
    test_reset_mid_rd();
    test_retry_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
